sram_pwr_ctrl: RTL and testbench

SRAM_PWR_CTRL -- requirements
Module: sram_pwr_ctrl

---
 rtl/sram_pwr_pkg.sv | 23 ++
 rtl/sram_pwr_ctrl.sv | 150 +++++++++++++++
 tb/tb_sram_pwr_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sram_pwr_pkg.sv
// Shared types for the SRAM bank power controller.
package sram_pwr_pkg;

    // Requested power mode as driven on mode_i.
    typedef enum logic [1:0] {
        MODE_ON   = 2'd0,
        MODE_RET  = 2'd1,
        MODE_OFF  = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Controller state, visible on state_o.
    typedef enum logic [2:0] {
        ST_ON     = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_RET    = 3'd2,
        ST_PWR_DN = 3'd3,
        ST_OFF    = 3'd4,
        ST_PWR_UP = 3'd5,
        ST_WAKE   = 3'd6
    } state_e;

endpackage

// File: rtl/sram_pwr_ctrl.sv
// SRAM bank power controller: sequences ON / retention / OFF transitions,
// gates bus grants while the macro is not fully powered, and flags a sticky
// error when the power switch fails to acknowledge in time.
module sram_pwr_ctrl
    import sram_pwr_pkg::*;
#(
    parameter int unsigned AckTimeout   = 32,
    parameter int unsigned WakeupCycles = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       mode_valid_i,
    input  logic [1:0] mode_i,
    output logic       mode_ready_o,
    input  logic       req_i,
    output logic       gnt_o,
    output logic       sram_req_o,
    output logic       pwrgate_no,
    input  logic       pwrgate_ack_ni,
    output logic       set_retentive_no,
    output logic [2:0] state_o,
    output logic       timeout_err_o
);

    localparam int unsigned CntMax = (AckTimeout > WakeupCycles) ? AckTimeout : WakeupCycles;
    localparam int unsigned CntW   = $clog2(CntMax + 1);
    // Counters are loaded with N-1 so a phase lasts at most N cycles.
    localparam logic [CntW-1:0] AckLoad  = CntW'(AckTimeout - 1);
    localparam logic [CntW-1:0] WakeLoad = CntW'(WakeupCycles - 1);

    state_e          state_q, state_d;
    mode_e           tgt_q, tgt_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;

    mode_e req_mode;
    logic  mode_acc;
    logic  cnt_last;

    assign req_mode = mode_e'(mode_i);
    assign mode_acc = mode_valid_i & mode_ready_o;
    assign cnt_last = (cnt_q == '0);

    // State-decoded outputs; the macro is powered and non-retentive by default.
    always_comb begin
        gnt_o            = 1'b0;
        mode_ready_o     = 1'b0;
        pwrgate_no       = 1'b1;
        set_retentive_no = 1'b1;
        case (state_q)
            ST_ON:     begin gnt_o = 1'b1; mode_ready_o = 1'b1; end
            ST_RET:    begin set_retentive_no = 1'b0; mode_ready_o = 1'b1; end
            ST_PWR_DN: pwrgate_no = 1'b0;
            ST_OFF:    begin pwrgate_no = 1'b0; mode_ready_o = 1'b1; end
            default:   ;
        endcase
    end

    assign sram_req_o    = req_i & gnt_o;
    assign state_o       = state_q;
    assign timeout_err_o = err_q;

    // Next-state, shared phase counter and sticky timeout flag.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_ON: begin
                // Redundant and reserved requests are accepted and ignored.
                if (mode_acc && (req_mode == MODE_RET || req_mode == MODE_OFF)) begin
                    state_d = ST_DRAIN;
                    tgt_d   = req_mode;
                end
            end
            ST_DRAIN: begin
                // One cycle lets the last granted read return before power changes.
                if (tgt_q == MODE_OFF) begin
                    state_d = ST_PWR_DN;
                    cnt_d   = AckLoad;
                end else begin
                    state_d = ST_RET;
                end
            end
            ST_RET: begin
                if (mode_acc && req_mode == MODE_OFF) begin
                    state_d = ST_PWR_DN;
                    cnt_d   = AckLoad;
                end else if (mode_acc && req_mode == MODE_ON) begin
                    state_d = ST_WAKE;
                    cnt_d   = WakeLoad;
                end
            end
            ST_PWR_DN: begin
                if (!pwrgate_ack_ni) begin
                    state_d = ST_OFF;
                end else if (cnt_last) begin
                    state_d = ST_OFF;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ST_OFF: begin
                // RET from OFF cannot restore contents, so it is a no-op.
                if (mode_acc && req_mode == MODE_ON) begin
                    state_d = ST_PWR_UP;
                    cnt_d   = AckLoad;
                end
            end
            ST_PWR_UP: begin
                if (pwrgate_ack_ni) begin
                    state_d = ST_WAKE;
                    cnt_d   = WakeLoad;
                end else if (cnt_last) begin
                    state_d = ST_WAKE;
                    cnt_d   = WakeLoad;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            ST_WAKE: begin
                if (cnt_last) begin
                    state_d = ST_ON;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = ST_ON;
        endcase
    end

    // State register; reset returns straight to ON regardless of phase.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_ON;
            tgt_q   <= MODE_RET;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_sram_pwr_ctrl.sv
// Scoreboard bench for sram_pwr_ctrl: the stimulus side plans the expected
// per-cycle observation of each power transition and queues it; a monitor
// compares every cycle on the falling edge.
module tb_sram_pwr_ctrl;
    import sram_pwr_pkg::*;

    localparam int AT = 32;
    localparam int WC = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       mode_valid_i = 1'b0;
    logic [1:0] mode_i = 2'd0;
    logic       req_i = 1'b0;
    logic       pwrgate_ack_ni = 1'b1;
    logic       mode_ready_o, gnt_o, sram_req_o, pwrgate_no, set_retentive_no, timeout_err_o;
    logic [2:0] state_o;

    sram_pwr_ctrl #(.AckTimeout(AT), .WakeupCycles(WC)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .mode_valid_i(mode_valid_i), .mode_i(mode_i), .mode_ready_o(mode_ready_o),
        .req_i(req_i), .gnt_o(gnt_o), .sram_req_o(sram_req_o),
        .pwrgate_no(pwrgate_no), .pwrgate_ack_ni(pwrgate_ack_ni),
        .set_retentive_no(set_retentive_no), .state_o(state_o),
        .timeout_err_o(timeout_err_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic gnt, sreq, pg, ret, rdy, err;
    } obs_t;

    obs_t   exp_q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    bit     started = 0;

    // Reference model: stable mode state, sticky error, planned transient states.
    state_e cur = ST_ON;
    logic   m_err = 1'b0;
    state_e plan_st[$];
    bit     plan_err[$];

    // Ack stub: ack follows pwrgate_no ack_dly cycles later, or freezes.
    int     ack_dly = 1;
    bit     ack_stuck = 0;
    logic   hist[$];

    initial begin
        for (int i = 0; i < 64; i++) hist.push_back(1'b1);
        forever begin
            @(negedge clk);
            hist.push_front(pwrgate_no);
            void'(hist.pop_back());
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (!ack_stuck) pwrgate_ack_ni = hist[ack_dly-1];
        end
    end

    // What a bank in a given state presents on its outputs.
    function automatic obs_t expect_obs(input state_e s, input logic req, input logic err);
        obs_t o;
        o.st   = s;
        o.gnt  = (s == ST_ON);
        o.sreq = req && (s == ST_ON);
        o.pg   = !(s == ST_PWR_DN || s == ST_OFF);
        o.ret  = (s != ST_RET);
        o.rdy  = (s == ST_ON || s == ST_RET || s == ST_OFF);
        o.err  = err;
        return o;
    endfunction

    task automatic step(input bit v, input logic [1:0] m, input state_e s, input logic err);
        @(posedge clk);
        #1;
        mode_valid_i = v;
        mode_i       = m;
        req_i        = 1'($urandom_range(0, 1));
        exp_q.push_back(expect_obs(s, req_i, err));
        started = 1;
    endtask

    task automatic rst_step(input bit assert_rst);
        @(posedge clk);
        #1;
        rst_ni       = !assert_rst;
        mode_valid_i = 1'b0;
        req_i        = 1'($urandom_range(0, 1));
        plan_st.delete();
        plan_err.delete();
        cur       = ST_ON;
        m_err     = 1'b0;
        ack_stuck = 0;
        exp_q.push_back(expect_obs(ST_ON, req_i, 1'b0));
        started = 1;
    endtask

    // One cycle of the planned trajectory; mode requests in busy states must be ignored.
    task automatic idle();
        state_e s;
        bit     busy;
        s = cur;
        if (plan_st.size() > 0) begin
            s = plan_st.pop_front();
            if (plan_err.pop_front()) m_err = 1'b1;
        end
        busy = !(s == ST_ON || s == ST_RET || s == ST_OFF);
        if (busy) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), s, m_err);
        else      step(1'b0, 2'd0, s, m_err);
    endtask

    task automatic add(input state_e s, input int n, input bit e);
        for (int i = 0; i < n; i++) begin
            plan_st.push_back(s);
            plan_err.push_back(e && i == 0);
        end
    endtask

    task automatic settle(input int gap);
        while (plan_st.size() > 0) idle();
        ack_stuck = 0;
        repeat (gap) idle();
    endtask

    // Issue one accepted mode request and plan the resulting state sequence.
    task automatic issue(input logic [1:0] m, input int d, input bit stuck, input int gap);
        bit to;
        int n;
        to = stuck || (d >= AT);
        n  = to ? AT : d + 1;
        ack_dly   = d;
        ack_stuck = stuck;
        step(1'b1, m, cur, m_err);
        case (cur)
            ST_ON: begin
                if (m == MODE_RET) begin
                    add(ST_DRAIN, 1, 0); add(ST_RET, 1, 0); cur = ST_RET;
                end else if (m == MODE_OFF) begin
                    add(ST_DRAIN, 1, 0); add(ST_PWR_DN, n, 0); add(ST_OFF, 1, to); cur = ST_OFF;
                end
            end
            ST_RET: begin
                if (m == MODE_OFF) begin
                    add(ST_PWR_DN, n, 0); add(ST_OFF, 1, to); cur = ST_OFF;
                end else if (m == MODE_ON) begin
                    add(ST_WAKE, WC, 0); add(ST_ON, 1, 0); cur = ST_ON;
                end
            end
            ST_OFF: begin
                if (m == MODE_ON) begin
                    add(ST_PWR_UP, n, 0); add(ST_WAKE, WC, to); add(ST_ON, 1, 0); cur = ST_ON;
                end
            end
            default: ;
        endcase
        if (gap >= 0) settle(gap);
    endtask

    // Monitor: compare one observation per cycle against the queued expectation.
    initial begin
        obs_t a, e;
        forever begin
            @(negedge clk);
            a = {state_o, gnt_o, sram_req_o, pwrgate_no, set_retentive_no, mode_ready_o, timeout_err_o};
            if (exp_q.size() == 0) begin
                if (started) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard_empty t=%0t no expectation for observed st=%0d", $time, a.st);
                end
            end else begin
                e = exp_q.pop_front();
                n_chk++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle_obs t=%0t got st=%0d gnt=%b sreq=%b pg=%b ret=%b rdy=%b err=%b exp st=%0d gnt=%b sreq=%b pg=%b ret=%b rdy=%b err=%b",
                             $time, a.st, a.gnt, a.sreq, a.pg, a.ret, a.rdy, a.err,
                             e.st, e.gnt, e.sreq, e.pg, e.ret, e.rdy, e.err);
                end
            end
        end
    end

    initial begin
        #1_500_000;
        n_fail++;
        $display("FAIL watchdog t=%0t stimulus did not complete", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        int r, d;
        rst_step(1); rst_step(1); rst_step(0);
        settle(3);
        issue(MODE_RET, 2, 0, 10);   // drain then retention, grants held off
        issue(MODE_ON, 1, 0, 10);    // 4 wake cycles then grant
        issue(MODE_OFF, 3, 0, 40);   // ack three cycles after gating, no error
        issue(MODE_RET, 1, 0, 5);    // RET in OFF: accepted, no change
        issue(MODE_RSVD, 1, 0, 5);   // reserved: accepted, no change
        issue(MODE_OFF, 1, 0, 5);    // same mode: no change
        issue(MODE_ON, 2, 0, 40);
        issue(MODE_ON, 1, 0, 5);
        issue(MODE_RSVD, 1, 0, 5);
        issue(MODE_OFF, AT-1, 0, 40); // latest ack that still avoids timeout
        issue(MODE_ON, 2, 0, 40);
        issue(MODE_OFF, 1, 1, 40);   // ack stuck high: timeout after AT cycles
        issue(MODE_ON, 1, 0, 40);    // error stays sticky
        issue(MODE_OFF, 2, 0, 40);
        issue(MODE_ON, 1, 1, -1);    // power-up with ack stuck low, then reset mid-way
        idle(); idle(); idle();
        rst_step(1); rst_step(0);
        settle(40);
        for (int k = 0; k < 60; k++) begin
            r = int'($urandom_range(0, 9));
            d = int'($urandom_range(1, 6));
            if (r == 0) d = AT - 1 + int'($urandom_range(0, 2));
            issue(2'($urandom_range(0, 3)), d, (r == 1), 40);
        end
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
